// File: rtl/crc_pkg.sv
// -----------------------------------------------------------------------------
// crc_pkg
// Shared definitions for the serial CRC framer:
//   - state_t    : framer FSM state encoding
//   - CRC*_POLY  : common generator polynomials. The implicit x^CRC_W term is
//                  omitted.
//   - max_u      : helper used to size the shared data/CRC bit counter
// -----------------------------------------------------------------------------
package crc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_CRC  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [2:0]  CRC3_POLY        = 3'b011;
    localparam logic [7:0]  CRC8_POLY        = 8'h07;
    localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/crc_lfsr.sv
// -----------------------------------------------------------------------------
// crc_lfsr
// MSB-first serial CRC shift register (Galois form).
//   GCLK     in   clock, rising edge
//   CLEAR    in   synchronous active-high reset, loads INIT
//   load     in   load INIT (frame start)
//   shift_en in   shift one position this cycle
//   feed_en  in   1: feedback = din ^ crc[MSB] (accumulate)
//                 0: plain shift with zero fill (unload remainder)
//   din      in   serial data bit
//   crc      out  current register contents
// -----------------------------------------------------------------------------
module crc_lfsr
    import crc_pkg::*;
#(
    parameter int                 CRC_W = 3,
    parameter logic [CRC_W-1:0]   POLY  = CRC3_POLY,
    parameter logic [CRC_W-1:0]   INIT  = {CRC_W{1'b0}}
) (
    input  logic             GCLK,
    input  logic             CLEAR,
    input  logic             load,
    input  logic             shift_en,
    input  logic             feed_en,
    input  logic             din,
    output logic [CRC_W-1:0] crc
);

    logic [CRC_W-1:0] r_crc;
    logic             w_fb;
    logic [CRC_W-1:0] w_crc_next;

    // Next-value computation for one shift step.
    always_comb begin
        w_fb       = feed_en & (din ^ r_crc[CRC_W-1]);
        w_crc_next = {r_crc[CRC_W-2:0], 1'b0} ^ (w_fb ? POLY : {CRC_W{1'b0}});
    end

    // CRC register: reset/load to INIT, otherwise shift when enabled.
    always_ff @(posedge GCLK) begin
        if (CLEAR) begin
            r_crc <= INIT;
        end else if (load) begin
            r_crc <= INIT;
        end else if (shift_en) begin
            r_crc <= w_crc_next;
        end else begin
            r_crc <= r_crc;
        end
    end

    assign crc = r_crc;

endmodule

// File: rtl/crc_serial_framer.sv
// -----------------------------------------------------------------------------
// crc_serial_framer
// Serial CRC generator with built-in framing. On Start (sampled in IDLE) it
// passes FRAME_LEN data bits straight through, then appends the CRC_W-bit
// remainder MSB-first. One DONE cycle follows each frame.
//
// Optional build macro CRC_CHECK_EN adds receive-side checking:
//   Check_Mode in  sampled with Start, held for the frame
//   Crc_Err    out set from (crc != 0) at the edge leaving DONE, held until the
//                  next accepted Start or CLEAR
//
// Ports:
//   GCLK       in   clock, rising edge
//   CLEAR      in   synchronous active-high reset (overrides everything)
//   Start      in   frame start request, only honoured in IDLE
//   Serial_In  in   data bit, one per cycle in DATA
//   Serial_Out out  link bit (combinational mux)
//   Out_Valid  out  high while Serial_Out carries a frame bit
//   Busy       out  high in DATA or CRC
//   Done       out  one-cycle pulse after the last CRC bit
// -----------------------------------------------------------------------------
module crc_serial_framer
    import crc_pkg::*;
#(
    parameter int               CRC_W     = 3,
    parameter logic [CRC_W-1:0] POLY      = CRC3_POLY,
    parameter int               FRAME_LEN = 8,
    parameter logic [CRC_W-1:0] INIT      = {CRC_W{1'b0}}
) (
    input  logic GCLK,
    input  logic CLEAR,
    input  logic Start,
    input  logic Serial_In,
`ifdef CRC_CHECK_EN
    input  logic Check_Mode,
    output logic Crc_Err,
`endif
    output logic Serial_Out,
    output logic Out_Valid,
    output logic Busy,
    output logic Done
);

    // One counter serves both phases, so it is sized for the longer of the two.
    localparam int unsigned CNT_MAX = max_u(FRAME_LEN, CRC_W);
    localparam int          CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(CRC_W - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_load;
    logic             w_shift;
    logic             w_feed;
    logic             w_cnt_clr;
    logic             w_cnt_inc;
    logic             w_check_mode;
    logic [CRC_W-1:0] w_crc;

    crc_lfsr #(
        .CRC_W (CRC_W),
        .POLY  (POLY),
        .INIT  (INIT)
    ) u_lfsr (
        .GCLK     (GCLK),
        .CLEAR    (CLEAR),
        .load     (w_load),
        .shift_en (w_shift),
        .feed_en  (w_feed),
        .din      (Serial_In),
        .crc      (w_crc)
    );

`ifdef CRC_CHECK_EN
    logic r_check_mode;
    logic r_crc_err;

    // Check-mode latch and error flag; both cleared when a new frame starts.
    always_ff @(posedge GCLK) begin
        if (CLEAR) begin
            r_check_mode <= 1'b0;
            r_crc_err    <= 1'b0;
        end else if ((r_state == ST_IDLE) && Start) begin
            r_check_mode <= Check_Mode;
            r_crc_err    <= 1'b0;
        end else if (r_state == ST_DONE) begin
            r_check_mode <= r_check_mode;
            r_crc_err    <= (w_crc != {CRC_W{1'b0}});
        end else begin
            r_check_mode <= r_check_mode;
            r_crc_err    <= r_crc_err;
        end
    end

    assign w_check_mode = r_check_mode;
    assign Crc_Err      = r_crc_err;
`else
    // Generation-only build: only the MSB of the register is observed.
    logic w_unused_crc_low;
    assign w_check_mode     = 1'b0;
    assign w_unused_crc_low = ^w_crc[CRC_W-2:0];
`endif

    // FSM state register.
    always_ff @(posedge GCLK) begin
        if (CLEAR) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Bit counter: cleared at each phase boundary, so it never wraps.
    always_ff @(posedge GCLK) begin
        if (CLEAR) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (w_cnt_clr) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Next-state, LFSR control and output mux.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_feed       = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        Serial_Out   = 1'b0;
        Out_Valid    = 1'b0;
        Busy         = 1'b0;
        Done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (Start) begin
                    w_next_state = ST_DATA;
                    w_load       = 1'b1;
                    w_cnt_clr    = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_DATA: begin
                Serial_Out = Serial_In;
                Out_Valid  = 1'b1;
                Busy       = 1'b1;
                w_shift    = 1'b1;
                w_feed     = 1'b1;
                if (r_cnt == DATA_LAST) begin
                    w_next_state = ST_CRC;
                    w_cnt_clr    = 1'b1;
                end else begin
                    w_cnt_inc    = 1'b1;
                end
            end
            ST_CRC: begin
                Out_Valid = 1'b1;
                Busy      = 1'b1;
                w_shift   = 1'b1;
                // Checking keeps folding received bits in so a clean frame
                // leaves a zero remainder; generation just unloads the register.
                w_feed    = w_check_mode;
                if (w_check_mode) begin
                    Serial_Out = Serial_In;
                end else begin
                    Serial_Out = w_crc[CRC_W-1];
                end
                if (r_cnt == CRC_LAST) begin
                    w_next_state = ST_DONE;
                    w_cnt_clr    = 1'b1;
                end else begin
                    w_cnt_inc    = 1'b1;
                end
            end
            ST_DONE: begin
                Done         = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_crc_serial_framer.sv
module tb_crc_serial_framer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic clear, start_a, sin_a, start_b, sin_b, chk;
    logic so_a, ov_a, busy_a, done_a;
    logic so_i, ov_i, busy_i, done_i;
    logic so_b, ov_b, busy_b, done_b;
`ifdef CRC_CHECK_EN
    logic err_a, err_i, err_b;
`endif

    int errors = 0;
    int checks = 0;

    // CRC-3, FRAME_LEN=4, INIT=0
    crc_serial_framer #(.CRC_W(3), .POLY(3'b011), .FRAME_LEN(4), .INIT(3'b000)) dut_a (
        .GCLK(clk), .CLEAR(clear), .Start(start_a), .Serial_In(sin_a),
`ifdef CRC_CHECK_EN
        .Check_Mode(chk), .Crc_Err(err_a),
`endif
        .Serial_Out(so_a), .Out_Valid(ov_a), .Busy(busy_a), .Done(done_a));

    // CRC-3, FRAME_LEN=4, INIT=3'b111 (shares stimulus with dut_a)
    crc_serial_framer #(.CRC_W(3), .POLY(3'b011), .FRAME_LEN(4), .INIT(3'b111)) dut_i (
        .GCLK(clk), .CLEAR(clear), .Start(start_a), .Serial_In(sin_a),
`ifdef CRC_CHECK_EN
        .Check_Mode(chk), .Crc_Err(err_i),
`endif
        .Serial_Out(so_i), .Out_Valid(ov_i), .Busy(busy_i), .Done(done_i));

    // CRC-8 (0x07), FRAME_LEN=8, INIT=0
    crc_serial_framer #(.CRC_W(8), .POLY(8'h07), .FRAME_LEN(8), .INIT(8'h00)) dut_b (
        .GCLK(clk), .CLEAR(clear), .Start(start_b), .Serial_In(sin_b),
`ifdef CRC_CHECK_EN
        .Check_Mode(chk), .Crc_Err(err_b),
`endif
        .Serial_Out(so_b), .Out_Valid(ov_b), .Busy(busy_b), .Done(done_b));

    // Bitwise MSB-first CRC reference
    function automatic logic [31:0] crc_sw(input int w, input logic [31:0] poly,
                                           input logic [31:0] init, input logic [31:0] data,
                                           input int n);
        logic [31:0] c;
        logic [31:0] mask;
        logic        fb;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        c = init & mask;
        for (int k = n - 1; k >= 0; k--) begin
            fb = data[k] ^ c[w-1];
            c  = (c << 1) & mask;
            if (fb) c = c ^ poly;
        end
        return c;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        clear = 1'b1; start_a = 1'b0; sin_a = 1'b0; start_b = 1'b0; sin_b = 1'b0; chk = 1'b0;
        repeat (2) tick;
        @(negedge clk);
        checks++;
        if ({so_a, ov_a, busy_a, done_a, so_i, ov_i, busy_i, done_i, so_b, ov_b, busy_b, done_b} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {so_a, ov_a, busy_a, done_a, so_i, ov_i, busy_i, done_i, so_b, ov_b, busy_b, done_b});
        end
        // Start while CLEAR is high must be overridden
        start_a = 1'b1; start_b = 1'b1;
        tick;
        start_a = 1'b0; start_b = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy_a, ov_a, busy_b, ov_b} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_overrides_start: busy/ov=%b expected 0000", {busy_a, ov_a, busy_b, ov_b});
        end
        tick;
        clear = 1'b0;
    endtask

    // One CRC-3 frame on dut_a/dut_i; start_a held at 'hold' after the start cycle
    task automatic frame_a(input logic [3:0] d, input logic [2:0] exp_a, input logic [2:0] exp_i,
                           input logic hold, input string tag);
        start_a = 1'b1; sin_a = 1'b0;
        @(negedge clk);
        checks++;
        if ({ov_a, busy_a, ov_i, busy_i} !== 4'b0000) begin
            errors++;
            $display("FAIL %s idle: ov/busy=%b expected 0000", tag, {ov_a, busy_a, ov_i, busy_i});
        end
        for (int i = 0; i < 4; i++) begin
            tick;
            start_a = hold; sin_a = d[3-i];
            @(negedge clk);
            checks++;
            if ({so_a, ov_a, busy_a, so_i, ov_i, busy_i} !== {d[3-i], 2'b11, d[3-i], 2'b11}) begin
                errors++;
                $display("FAIL %s data%0d: so/ov/busy(a,i)=%b expected %b", tag, i,
                         {so_a, ov_a, busy_a, so_i, ov_i, busy_i}, {d[3-i], 2'b11, d[3-i], 2'b11});
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick;
            sin_a = 1'($urandom);
            @(negedge clk);
            checks++;
            if ({so_a, ov_a, busy_a, so_i, ov_i} !== {exp_a[2-i], 2'b11, exp_i[2-i], 1'b1}) begin
                errors++;
                $display("FAIL %s crc%0d: so/ov/busy a, so/ov i=%b expected %b", tag, i,
                         {so_a, ov_a, busy_a, so_i, ov_i}, {exp_a[2-i], 2'b11, exp_i[2-i], 1'b1});
            end
        end
        tick;
        sin_a = 1'b0;
        @(negedge clk);
        checks++;
        if ({done_a, busy_a, ov_a, so_a, done_i} !== 5'b10001) begin
            errors++;
            $display("FAIL %s done: done/busy/ov/so/done_i=%b expected 10001", tag,
                     {done_a, busy_a, ov_a, so_a, done_i});
        end
        tick;
        @(negedge clk);
        checks++;
        if ({done_a, ov_a, so_a} !== 3'b000) begin
            errors++;
            $display("FAIL %s after_done: done/ov/so=%b expected 000", tag, {done_a, ov_a, so_a});
        end
    endtask

    task automatic frame_b(input logic [7:0] d, input logic [7:0] exp_crc, input string tag);
        tick;
        start_b = 1'b1; sin_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick;
            start_b = 1'b0; sin_b = d[7-i];
            @(negedge clk);
            checks++;
            if ({so_b, ov_b, busy_b} !== {d[7-i], 2'b11}) begin
                errors++;
                $display("FAIL %s data%0d: so/ov/busy=%b expected %b", tag, i, {so_b, ov_b, busy_b}, {d[7-i], 2'b11});
            end
        end
        for (int i = 0; i < 8; i++) begin
            tick;
            sin_b = 1'($urandom);
            @(negedge clk);
            checks++;
            if ({so_b, ov_b} !== {exp_crc[7-i], 1'b1}) begin
                errors++;
                $display("FAIL %s crc%0d: so/ov=%b expected %b (crc %h)", tag, i, {so_b, ov_b}, {exp_crc[7-i], 1'b1}, exp_crc);
            end
        end
        tick;
        sin_b = 1'b0;
        @(negedge clk);
        checks++;
        if ({done_b, busy_b, ov_b} !== 3'b100) begin
            errors++;
            $display("FAIL %s done: done/busy/ov=%b expected 100", tag, {done_b, busy_b, ov_b});
        end
    endtask

    task automatic test_basic;
        tick;
        frame_a(4'b1101, 3'b001, 3'b101, 1'b0, "basic_1101");
    endtask

    task automatic test_zero_data;
        tick;
        frame_a(4'b0000, 3'b000, crc_sw(3, 32'h3, 32'h7, 32'h0, 4), 1'b0, "zero_data");
    endtask

    task automatic test_clear_mid_frame;
        tick;
        start_a = 1'b1;
        tick; start_a = 1'b0; sin_a = 1'b1;
        tick; sin_a = 1'b0;
        tick; sin_a = 1'b1; clear = 1'b1;
        tick; clear = 1'b0; sin_a = 1'b0;
        @(negedge clk);
        checks++;
        if ({ov_a, busy_a, done_a, so_a} !== 4'b0000) begin
            errors++;
            $display("FAIL clear_mid: ov/busy/done/so=%b expected 0000", {ov_a, busy_a, done_a, so_a});
        end
        for (int i = 0; i < 6; i++) begin
            tick;
            @(negedge clk);
            checks++;
            if ({done_a, busy_a} !== 2'b00) begin
                errors++;
                $display("FAIL clear_mid_quiet%0d: done/busy=%b expected 00", i, {done_a, busy_a});
            end
        end
        tick;
        frame_a(4'b1001, 3'b110, crc_sw(3, 32'h3, 32'h7, 32'h9, 4), 1'b0, "after_clear");
    endtask

    task automatic test_start_held;
        tick;
        frame_a(4'b0110, 3'b001, crc_sw(3, 32'h3, 32'h7, 32'h6, 4), 1'b1, "start_held");
        // Start still high in IDLE: the next frame begins
        tick;
        @(negedge clk);
        checks++;
        if ({busy_a, ov_a} !== 2'b11) begin
            errors++;
            $display("FAIL start_held_next: busy/ov=%b expected 11", {busy_a, ov_a});
        end
        start_a = 1'b0;
        clear = 1'b1;
        tick;
        clear = 1'b0;
    endtask

    task automatic test_crc8;
        logic [7:0] d;
        frame_b(8'h31, 8'h97, "crc8_0x31");
        for (int n = 0; n < 200; n++) begin
            d = 8'($urandom);
            frame_b(d, 8'(crc_sw(8, 32'h07, 32'h0, {24'h0, d}, 8)), "crc8_rand");
        end
    endtask

`ifdef CRC_CHECK_EN
    task automatic check_frame(input logic [6:0] bits, input logic exp_err, input string tag);
        tick;
        start_a = 1'b1; chk = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick;
            start_a = 1'b0; chk = 1'b0; sin_a = bits[6-i];
            @(negedge clk);
            checks++;
            if ({so_a, ov_a} !== {bits[6-i], 1'b1}) begin
                errors++;
                $display("FAIL %s bit%0d: so/ov=%b expected %b", tag, i, {so_a, ov_a}, {bits[6-i], 1'b1});
            end
        end
        tick;
        sin_a = 1'b0;
        @(negedge clk);
        checks++;
        if (done_a !== 1'b1) begin
            errors++;
            $display("FAIL %s done: got %b expected 1", tag, done_a);
        end
        for (int i = 0; i < 3; i++) begin
            tick;
            @(negedge clk);
            checks++;
            if (err_a !== exp_err) begin
                errors++;
                $display("FAIL %s crc_err%0d: got %b expected %b", tag, i, err_a, exp_err);
            end
        end
    endtask

    task automatic test_check_mode;
        check_frame(7'b1101001, 1'b0, "check_good");
        check_frame(7'b1100001, 1'b1, "check_flip");
        tick;
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
        @(negedge clk);
        checks++;
        if (err_a !== 1'b0) begin
            errors++;
            $display("FAIL check_err_cleared_on_start: got %b expected 0", err_a);
        end
        clear = 1'b1;
        tick;
        clear = 1'b0;
    endtask
`endif

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_zero_data();
        test_clear_mid_frame();
        test_start_held();
        test_crc8();
`ifdef CRC_CHECK_EN
        test_check_mode();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
